// File: rtl/ahbl_slave_mem.sv
// -----------------------------------------------------------------------------
// ahbl_slave_mem
//
// AHB-Lite responder backed by a word-addressed internal memory. It answers
// transfers from the AHB-Lite master BFM. It supports programmable wait states,
// a byte-address window that always answers with ERROR, and misalignment
// checking.
//
// Parameters
//   MEM_WORDS   memory depth in 32-bit words (power of 2). Address bits above
//               the word index are ignored, so accesses wrap.
//   WAIT_STATES HREADYOUT-low cycles at the start of every data phase (0..15)
//   ERR_BASE    first byte address of the error window
//   ERR_SIZE    size of the error window in bytes (0 disables the window)
//
// Ports
//   HCLK        clock, rising edge
//   HRESET      synchronous active-high reset
//   HSEL        slave select
//   HADDR       byte address
//   HTRANS      IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   HWRITE      1 = write
//   HSIZE       0 = byte, 1 = halfword, 2 = word (larger sizes answer ERROR)
//   HBURST      accepted, ignored
//   HPROT       accepted, ignored
//   HMASTLOCK   accepted, ignored
//   HWDATA      write data, valid in the data phase
//   HREADY      bus-level ready (HREADYIN)
//   HREADYOUT   slave ready
//   HRESP       0 = OKAY, 1 = ERROR
//   HRDATA      read data; zero outside a read OKAY completion cycle
//   XFER_COUNT  transfers completed with OKAY, wraps at 16 bits
// -----------------------------------------------------------------------------
module ahbl_slave_mem #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ERR_BASE    = 32'hFFFF_0000,
    parameter logic [31:0] ERR_SIZE    = 32'h0000_0100
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [15:0] XFER_COUNT
);

    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam bit          HAS_WAIT  = (WAIT_STATES > 0);
    // The counter runs from WAIT_STATES-1 down to 0, one wait cycle per value.
    localparam logic [3:0]  WAIT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // 33-bit compare so a window that ends at the top of the address space
    // does not wrap its upper bound to zero.
    function automatic logic in_err_window(input logic [31:0] addr);
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] a;
        lo = {1'b0, ERR_BASE};
        hi = lo + {1'b0, ERR_SIZE};
        a  = {1'b0, addr};
        return (ERR_SIZE != 32'd0) && (a >= lo) && (a < hi);
    endfunction

    function automatic logic bad_size_or_align(input logic [2:0] size,
                                               input logic [1:0] addr_lo);
        logic bad;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = addr_lo[0];
            3'd2:    bad = (addr_lo != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian byte lanes for an aligned transfer.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size,
                                              input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            3'd0:    be = 4'b0001 << addr_lo;
            3'd1:    be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Control state
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dphase_q, dphase_d;     // OKAY completion cycle pending in IDLE
    logic [15:0] count_q, count_d;
    logic        hreadyout_q, hreadyout_d;
    logic        hresp_q, hresp_d;

    // Address-phase capture
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [MEM_WORDS];

    logic             accept;
    logic             req_err;
    logic             ok_done;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [IDX_W-1:0] word_idx;

    // A new address phase is only taken while this slave is not stalling the
    // bus (IDLE or the second ERROR cycle).
    assign accept  = HSEL && HREADY && HTRANS[1] &&
                     ((state_q == ST_IDLE) || (state_q == ST_ERR2));
    assign req_err = in_err_window(HADDR) || bad_size_or_align(HSIZE, HADDR[1:0]);
    assign ok_done = (state_q == ST_IDLE) && dphase_q;

    assign word_idx = addr_q[IDX_W+1:2];
    assign mem_be   = byte_lanes(size_q, addr_q[1:0]);
    // A reset in the completion cycle aborts the transfer, so the write is gated.
    assign mem_we   = ok_done && write_q && !HRESET;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dphase_d = 1'b0;
        count_d  = count_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
        err_d    = err_q;

        if (ok_done) begin
            count_d = count_q + 16'd1;
        end

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (err_q) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d  = ST_IDLE;
                        dphase_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Only legal from IDLE or ERR2, so it overrides the default transition.
        if (accept) begin
            addr_d  = HADDR;
            write_d = HWRITE;
            size_d  = HSIZE;
            err_d   = req_err;
            if (HAS_WAIT) begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_INIT;
            end else if (req_err) begin
                state_d = ST_ERR1;
            end else begin
                state_d  = ST_IDLE;
                dphase_d = 1'b1;
            end
        end

        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            dphase_q    <= 1'b0;
            count_q     <= 16'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dphase_q    <= dphase_d;
            count_q     <= count_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Captured address-phase fields are only consumed after an accept.
    always_ff @(posedge HCLK) begin
        addr_q  <= addr_d;
        write_q <= write_d;
        size_q  <= size_d;
        err_q   <= err_d;
    end

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HREADYOUT  = hreadyout_q;
    assign HRESP      = hresp_q;
    // Combinational from the array so a write closed at the previous edge is seen.
    assign HRDATA     = (ok_done && !write_q) ? mem_q[word_idx] : 32'd0;
    assign XFER_COUNT = count_q;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], addr_q};

endmodule
